// File: rtl/arb4way16_pkg.sv
// Shared definitions for the 4-way round-robin arbiter with lock.
//   - arb_state_e : arbiter FSM encoding (IDLE=0, LOCKED=1)
//   - REQ_A..REQ_D : requester index constants (A..D = 0..3)
//   - rr_next()    : round-robin successor of a requester index (3 wraps to 0)
`ifndef ARB4WAY16_PKG_SV
`define ARB4WAY16_PKG_SV

package arb4way16_pkg;

    localparam int NUM_REQ = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam logic [1:0] REQ_A = 2'd0;
    localparam logic [1:0] REQ_B = 2'd1;
    localparam logic [1:0] REQ_C = 2'd2;
    localparam logic [1:0] REQ_D = 2'd3;

    // 2-bit add wraps naturally, giving (idx+1) mod 4.
    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        return idx + 2'd1;
    endfunction

endpackage

`endif

// File: rtl/arb4way16_mux.sv
// Mux4Way16: 4-to-1 data selector feeding the arbiter output register.
// Ports:
//   a_i, b_i, c_i, d_i : WIDTH-bit data inputs (requesters A..D)
//   sel_i              : 2-bit select (0=A .. 3=D)
//   out_o              : selected data
module Mux4Way16
    import arb4way16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic [1:0]       sel_i,
    output logic [WIDTH-1:0] out_o
);

    always_comb begin
        unique case (sel_i)
            REQ_A:   out_o = a_i;
            REQ_B:   out_o = b_i;
            REQ_C:   out_o = c_i;
            default: out_o = d_i;
        endcase
    end

endmodule

// File: rtl/arb4way16.sv
// arb4way16: 4-requester round-robin arbiter with per-requester lock and a
// single registered output slot.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_A..in_D            : requester data (index 0..3 = A..D)
//   valid[3:0]            : requester i presents a beat
//   lock[3:0]             : requester i keeps ownership after this beat
//   ready[3:0]            : beat of requester i accepted this cycle (one-hot or 0)
//   out, out_src          : registered beat and its requester index
//   out_valid, out_ready  : output slot handshake
//   sel                   : combinational mux select for the current grant
module arb4way16
    import arb4way16_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int RESET_PTR = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic [WIDTH-1:0] in_C,
    input  logic [WIDTH-1:0] in_D,
    input  logic [3:0]       valid,
    input  logic [3:0]       lock,
    output logic [3:0]       ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_src,
    output logic [1:0]       sel
);

    arb_state_e       state_q;
    logic [1:0]       owner_q;
    logic [1:0]       ptr_q;
    logic [1:0]       sel_q;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic [1:0]       out_src_q;

    logic             cand_vld;
    logic [1:0]       cand_idx;
    logic [1:0]       scan_idx;
    logic             accept;
    logic             xfer;
    logic [WIDTH-1:0] mux_out;

    // Candidate selection. In IDLE, scan ptr..ptr+3 from the far end back so
    // the lowest offset from ptr is the last (winning) assignment. In LOCKED
    // only the owner may be chosen; a dropped owner valid just stalls.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = ptr_q;
        scan_idx = '0;
        if (state_q == ST_LOCKED) begin
            cand_vld = valid[owner_q];
            cand_idx = owner_q;
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                scan_idx = ptr_q + 2'(k);
                if (valid[scan_idx]) begin
                    cand_vld = 1'b1;
                    cand_idx = scan_idx;
                end
            end
        end
    end

    // Output slot can take a beat when empty or being drained this cycle.
    assign accept = !out_valid_q || out_ready;
    assign xfer   = accept && cand_vld && !reset;
    assign ready  = xfer ? (4'b0001 << cand_idx) : 4'b0000;

    // sel follows the candidate; with no candidate it holds the last value.
    assign sel = cand_vld ? cand_idx : sel_q;

    Mux4Way16 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a_i   (in_A),
        .b_i   (in_B),
        .c_i   (in_C),
        .d_i   (in_D),
        .sel_i (sel),
        .out_o (mux_out)
    );

    // Arbiter FSM, pointer and output slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= REQ_A;
            ptr_q       <= 2'(RESET_PTR);
            sel_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
        end else begin
            sel_q <= sel;
            if (xfer) begin
                out_q       <= mux_out;
                out_src_q   <= cand_idx;
                out_valid_q <= 1'b1;
                if (lock[cand_idx]) begin
                    state_q <= ST_LOCKED;
                    owner_q <= cand_idx;
                end else begin
                    // Unlocked beat (fresh or releasing) advances fairness.
                    state_q <= ST_IDLE;
                    ptr_q   <= rr_next(cand_idx);
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb4way16.sv
module tb_arb4way16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_A, in_B, in_C, in_D;
    logic [3:0]  valid, lock, ready;
    logic [15:0] out;
    logic        out_valid, out_ready;
    logic [1:0]  out_src, sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    arb4way16 #(.WIDTH(16), .RESET_PTR(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_C      (in_C),
        .in_D      (in_D),
        .valid     (valid),
        .lock      (lock),
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_src   (out_src),
        .sel       (sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after a rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive settle time before sampling combinational outputs.
    task automatic settle();
        #1;
    endtask

    logic [15:0] dat [4];

    initial begin
        dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333; dat[3] = 16'h4444;
        in_A = dat[0]; in_B = dat[1]; in_C = dat[2]; in_D = dat[3];
        reset = 1'b1; valid = 4'b1111; lock = 4'b0000; out_ready = 1'b1;
        cyc(); cyc();

        // Reset state: regs cleared, no ready even with all valid.
        settle();
        chk("rst_ready",     ready,     4'b0000);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out",       out,       16'h0000);
        chk("rst_out_src",   out_src,   2'd0);
        chk("rst_sel",       sel,       2'd0);

        // Round robin from ptr=0 with all requesters valid: A,B,C,D,A.
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("rr_ready", ready, 4'b0001 << (k % 4));
            chk("rr_sel",   sel,   k % 4);
            cyc();
            chk("rr_out_src",   out_src,   k % 4);
            chk("rr_out",       out,       dat[k % 4]);
            chk("rr_out_valid", out_valid, 1'b1);
        end
        // ptr now 1. Single C beat moves ptr to 3.
        valid = 4'b0100;
        settle(); chk("c_ready", ready, 4'b0100);
        cyc();    chk("c_out_src", out_src, 2'd2);

        // ptr=3, valid=1001: D, then A (wrap), then D.
        valid = 4'b1001;
        settle(); chk("wrap_d1", ready, 4'b1000); cyc(); chk("wrap_d1_src", out_src, 2'd3);
        settle(); chk("wrap_a",  ready, 4'b0001); cyc(); chk("wrap_a_src",  out_src, 2'd0);
        settle(); chk("wrap_d2", ready, 4'b1000); cyc(); chk("wrap_d2_src", out_src, 2'd3);

        // ptr=0. Lone A beat moves ptr to 1 so B wins the contended lock test.
        valid = 4'b0001;
        settle(); chk("pre_lock_a", ready, 4'b0001); cyc();

        // B locks for 3 beats, 4th unlocked: A starved throughout.
        valid = 4'b0011; lock = 4'b0010;
        settle(); chk("lock_b1", ready, 4'b0010); cyc(); chk("lock_b1_src", out_src, 2'd1);
        settle(); chk("lock_b2", ready, 4'b0010); cyc();
        // Owner drops valid: lock holds, A still gets nothing, sel holds B.
        valid = 4'b0001;
        settle(); chk("lock_gap_ready", ready, 4'b0000); chk("lock_gap_sel", sel, 2'd1);
        cyc();    chk("lock_gap_out_valid", out_valid, 1'b0);
        valid = 4'b0011;
        settle(); chk("lock_b3", ready, 4'b0010); cyc();
        lock = 4'b0000;
        settle(); chk("lock_b4", ready, 4'b0010); cyc(); chk("lock_b4_src", out_src, 2'd1);
        // Released, ptr=2: scan C,D,A -> A.
        settle(); chk("post_lock_a", ready, 4'b0001); cyc(); chk("post_lock_a_src", out_src, 2'd0);

        // Drain the slot with no transfer.
        valid = 4'b0000;
        settle(); chk("drain_ready", ready, 4'b0000);
        cyc();    chk("drain_out_valid", out_valid, 1'b0);

        // Backpressure: out_ready=0 for 3 cycles, one C transfer only.
        valid = 4'b0100; in_C = 16'hBEEF; out_ready = 1'b0;
        settle(); chk("bp_ready1", ready, 4'b0100); cyc();
        chk("bp_out1", out, 16'hBEEF); chk("bp_ov1", out_valid, 1'b1); chk("bp_src1", out_src, 2'd2);
        in_C = 16'h5555;
        settle(); chk("bp_ready2", ready, 4'b0000); cyc();
        chk("bp_out2", out, 16'hBEEF); chk("bp_ov2", out_valid, 1'b1);
        settle(); chk("bp_ready3", ready, 4'b0000); cyc();
        chk("bp_out3", out, 16'hBEEF); chk("bp_ov3", out_valid, 1'b1);
        in_C = dat[2];

        // Enter LOCKED(2) while consuming (slot full but out_ready=1).
        out_ready = 1'b1; lock = 4'b0100;
        settle(); chk("l2_ready", ready, 4'b0100); cyc();
        valid = 4'b0101;
        settle(); chk("l2_only_owner", ready, 4'b0100);
        // Reset mid-lock.
        reset = 1'b1;
        settle(); chk("l2_rst_ready", ready, 4'b0000);
        cyc();    chk("l2_rst_out_valid", out_valid, 1'b0); chk("l2_rst_out", out, 16'h0000);
        reset = 1'b0; lock = 4'b0000;
        // Lock discarded, ptr back to 0: A wins over C.
        settle(); chk("post_rst_a", ready, 4'b0001); cyc();
        chk("post_rst_src", out_src, 2'd0); chk("post_rst_out", out, dat[0]);

        // Single requester B toggling valid: beat only on valid cycles.
        for (int k = 0; k < 6; k++) begin
            in_B  = 16'hB000 + 16'(k);
            valid = (k % 2 == 0) ? 4'b0010 : 4'b0000;
            settle(); chk("tog_ready", ready, (k % 2 == 0) ? 4'b0010 : 4'b0000);
            cyc();
            chk("tog_out_valid", out_valid, (k % 2 == 0) ? 1'b1 : 1'b0);
            if (k % 2 == 0) chk("tog_out", out, 16'hB000 + 16'(k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
